// File: rtl/fracdiv_freqmeter.sv
// Counts rising edges of an asynchronous divider clock over a programmable window of clk_fast cycles.
// Each edge is counted 3 cycles after it rises, at window open and at window close alike.
module fracdiv_freqmeter #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              clk_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q;
  logic [2:0]        sync_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              busy_q, valid_q, ovf_q;
  logic [CNT_W-1:0]  count_q;
  logic              edge_p;

  // sync_q[1:0] is the synchronizer and sync_q[2] is the edge-detect register.
  assign edge_p = sync_q[1] & ~sync_q[2];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (edge_p && (state_q == MEASURE)) begin
      if (acc_q == CNT_MAX) sat_d = 1'b1;
      else                  acc_d = acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      gate_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], clk_in};
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            gate_q <= gate_len;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            if (gate_len != '0) begin
              state_q <= MEASURE;
              busy_q  <= 1'b1;
            end else begin
              // Empty window: publish a zero result straight away.
              state_q <= DONE;
              valid_q <= 1'b1;
              count_q <= '0;
              ovf_q   <= 1'b0;
            end
          end
        end
        MEASURE: begin
          acc_q  <= acc_d;
          sat_q  <= sat_d;
          gate_q <= gate_q - 1'b1;
          if (gate_q == GATE_W'(1)) begin
            // Result includes an edge landing in the final window cycle.
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            count_q <= acc_d;
            ovf_q   <= sat_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
